pdm_capture_dump: RTL and testbench
===================================

PDM_CAPTURE_DUMP -- requirements
Module: pdm_capture_dump

Interface
REQ-001 SHALL have parameter CLK_DIV_PDM, default 12: clk cycles per pdm_clk period; even, range 4..256.
REQ-002 SHALL have parameter BAUD_DIV, default 1250: clk cycles per UART bit; range 16..65535.
REQ-003 SHALL have parameter DEPTH, default 128: samples captured per channel; power of two, range 8..4096.
REQ-004 SHALL have parameter CHANNELS, default 1: PDM channels captured, 1 or 2; any other value is an elaboration error.
REQ-005 SHALL have parameter STOP_BITS, default 1: UART stop bits per character, range 1..4.
REQ-006 SHALL have port clk, input, 1: sole clock; every flop in the block is clocked by it.
REQ-007 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port ftdi_rx, input, 1: asynchronous UART rx line, used only as a trigger.
REQ-009 SHALL have port pdm_dat, input, 1: asynchronous microphone data.
REQ-010 SHALL have port pdm_clk, output, 1: registered microphone clock.
REQ-011 SHALL have port ftdi_tx, output, 1: UART 8N(STOP_BITS) transmit line, LSB first.
REQ-012 SHALL have port busy, output, 1: high whenever the state is not IDLE.
REQ-013 SHALL have port frame_toggle, output, 1: inverts once per completed capture.

Function
REQ-014 SHALL run the divider counter d from 0 to CLK_DIV_PDM-1 and wrap, free-running in every state; pdm_clk is registered as (d < CLK_DIV_PDM/2).
REQ-015 SHALL pass ftdi_rx and pdm_dat each through a two-flop synchroniser before any use.
REQ-016 SHALL implement the states IDLE, CAPTURE and DUMP only.
REQ-017 SHALL go IDLE->CAPTURE on the first clk after a synchronised ftdi_rx high-to-low edge; edges seen in CAPTURE or DUMP are ignored.
REQ-018 SHALL store the synchronised pdm_dat as a channel-0 sample in the cycle where d==CLK_DIV_PDM/2-1.
REQ-019 SHALL, when CHANNELS==2, store a channel-1 sample in the cycle where d==CLK_DIV_PDM-1.
REQ-020 SHALL start capture at the first ch0 sample point after entering CAPTURE, so buffer index 0 always holds channel 0.
REQ-021 SHALL go CAPTURE->DUMP in the cycle after the last sample of the last channel, at index DEPTH-1.
REQ-022 SHALL toggle frame_toggle in the same cycle as the CAPTURE->DUMP transition.
REQ-023 SHALL transmit all samples of channel 0 in index order 0..DEPTH-1, then, if CHANNELS==2, all samples of channel 1 in the same order.
REQ-024 SHALL encode each sample as one character: 0x30 for a 0 sample, 0x31 for a 1 sample.
REQ-025 SHALL frame each character as a start bit (0), 8 data bits, then STOP_BITS stop bits (1), each held exactly BAUD_DIV clk cycles.
REQ-026 SHALL start the next character's start bit in the cycle immediately after the previous character's last stop bit, with no idle gap.
REQ-027 SHALL go DUMP->IDLE after the final stop bit of the final character.
REQ-028 SHALL hold ftdi_tx at 1 in IDLE and CAPTURE; ftdi_tx is a registered output.
REQ-029 SHALL not accept a trigger in the same cycle as DUMP->IDLE; the earliest next trigger edge is detected one cycle after that.
REQ-030 SHALL keep the sample-index and baud counters wide enough that nothing wraps before the terminal count for any legal parameter value.

Reset
REQ-031 SHALL, while rst_n is low, force the state to IDLE, all counters to 0, pdm_clk=0, ftdi_tx=1, busy=0, frame_toggle=0 and synchroniser flops to 1.
REQ-032 SHALL abort any character mid-transmission on reset assertion, with ftdi_tx high asynchronously; the sample buffer is not reset.
REQ-033 SHALL require a fresh ftdi_rx falling edge after rst_n deasserts; a line already low at release does not trigger.

Configuration
REQ-034 SHALL, with PDM_DUMP_CRLF_EN defined, send 0x0D then 0x0A after each channel's DEPTH characters, before the next channel and before returning to IDLE.
REQ-035 SHALL, with PDM_DUMP_CRLF_EN undefined, send exactly DEPTH*CHANNELS characters per dump and nothing else.

Verification
REQ-036 Defaults, pdm_dat tied 1, one rx falling edge -> 128 chars of 0x31, each bit 1250 cycles, frame_toggle flips once, busy low after the last stop bit.
REQ-037 CLK_DIV_PDM=8, DEPTH=8, CHANNELS=2, pdm_dat high only at ch1 sample points -> "00000000" followed by "11111111".
REQ-038 DEPTH=8 with PDM_DUMP_CRLF_EN, alternating ch0 samples 0,1,... -> "01010101" 0x0D 0x0A, then IDLE.
REQ-039 Rx falling edges during CAPTURE and during DUMP -> exactly one dump occurs and frame_toggle flips exactly once.
REQ-040 rst_n pulsed low mid-character with STOP_BITS=2 -> ftdi_tx=1 immediately, state IDLE, no further characters until a new rx edge.
REQ-041 pdm_clk checked over 10 periods at CLK_DIV_PDM=12 -> high exactly 6 cycles and low exactly 6 cycles in every period.

Source files
------------

// File: rtl/pdm_capture_dump.sv
// PDM microphone capture into per-channel on-chip buffers, then an ASCII '0'/'1' dump over a UART.
// Optional build macro PDM_DUMP_CRLF_EN appends CR LF after each channel's block of characters.
module pdm_capture_dump #(
    parameter int CLK_DIV_PDM = 12,
    parameter int BAUD_DIV    = 1250,
    parameter int DEPTH       = 128,
    parameter int CHANNELS    = 1,
    parameter int STOP_BITS   = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ftdi_rx,
    input  logic pdm_dat,
    output logic pdm_clk,
    output logic ftdi_tx,
    output logic busy,
    output logic frame_toggle
);

    localparam int HALF       = CLK_DIV_PDM / 2;
    localparam int DW         = $clog2(CLK_DIV_PDM);
    localparam int AW         = $clog2(DEPTH);
    localparam int BW         = $clog2(BAUD_DIV);
    localparam int FRAME_BITS = 9 + STOP_BITS;

`ifdef PDM_DUMP_CRLF_EN
    localparam bit CRLF_EN = 1'b1;
`else
    localparam bit CRLF_EN = 1'b0;
`endif

    if (CHANNELS != 1 && CHANNELS != 2) begin : g_bad_channels
        $error("pdm_capture_dump: CHANNELS must be 1 or 2");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DUMP    = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [DW-1:0]   d_reg;
    logic            pdm_clk_reg;
    logic            rx_meta_reg, rx_sync_reg, rx_prev_reg;
    logic            dat_meta_reg, dat_sync_reg;
    logic [1:0]      settle_reg;
    logic            rx_fall;

    logic [AW-1:0]   idx_reg, idx_next;
    logic            chan_reg, chan_next;
    logic [1:0]      phase_reg, phase_next;
    logic [3:0]      bit_reg, bit_next;
    logic [BW-1:0]   baud_reg, baud_next;
    logic            started_reg, started_next;
    logic            toggle_reg, toggle_next;
    logic            tx_reg, tx_next;

    logic            wr_ch0, wr_ch1;
    logic            cap_done, blk_end;
    logic [CHANNELS-1:0] rd_bits;
    logic            rd_bit;
    logic [7:0]      char_code;

    // Free-running microphone clock divider, independent of the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_reg       <= '0;
            pdm_clk_reg <= 1'b0;
        end else begin
            d_reg       <= (d_reg == DW'(CLK_DIV_PDM - 1)) ? '0 : d_reg + DW'(1);
            pdm_clk_reg <= (d_reg < DW'(HALF));
        end
    end

    // settle_reg masks the edge detector until the synchroniser has flushed its reset ones,
    // so a line that is already low at reset release is not mistaken for a trigger.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_reg  <= 1'b1;
            rx_sync_reg  <= 1'b1;
            rx_prev_reg  <= 1'b1;
            dat_meta_reg <= 1'b1;
            dat_sync_reg <= 1'b1;
            settle_reg   <= 2'd0;
        end else begin
            rx_meta_reg  <= ftdi_rx;
            rx_sync_reg  <= rx_meta_reg;
            rx_prev_reg  <= rx_sync_reg;
            dat_meta_reg <= pdm_dat;
            dat_sync_reg <= dat_meta_reg;
            if (settle_reg != 2'd3) begin
                settle_reg <= settle_reg + 2'd1;
            end
        end
    end

    assign rx_fall = (settle_reg == 2'd3) && rx_prev_reg && !rx_sync_reg;

    // One sample buffer per channel; write and read share the running index.
    genvar gi;
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
        logic mem [DEPTH];
        logic rd_q;
        logic we;

        assign we = (gi == 0) ? wr_ch0 : wr_ch1;

        always_ff @(posedge clk) begin
            if (we) begin
                mem[idx_reg] <= dat_sync_reg;
            end
            rd_q <= mem[idx_reg];
        end

        assign rd_bits[gi] = rd_q;
    end

    assign rd_bit = chan_reg ? rd_bits[CHANNELS-1] : rd_bits[0];

    always_comb begin
        char_code = {7'b0011000, rd_bit};
        if (CRLF_EN && phase_reg == 2'd1) begin
            char_code = 8'h0D;
        end else if (CRLF_EN && phase_reg == 2'd2) begin
            char_code = 8'h0A;
        end
    end

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        chan_next    = chan_reg;
        phase_next   = phase_reg;
        bit_next     = bit_reg;
        baud_next    = baud_reg;
        started_next = started_reg;
        toggle_next  = toggle_reg;
        tx_next      = 1'b1;
        wr_ch0       = 1'b0;
        wr_ch1       = 1'b0;
        cap_done     = 1'b0;
        blk_end      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (rx_fall) begin
                    state_next   = CAPTURE;
                    idx_next     = '0;
                    started_next = 1'b0;
                end
            end

            CAPTURE: begin
                if (d_reg == DW'(HALF - 1)) begin
                    wr_ch0       = 1'b1;
                    started_next = 1'b1;
                    if (CHANNELS == 1) begin
                        if (idx_reg == AW'(DEPTH - 1)) begin
                            cap_done = 1'b1;
                        end else begin
                            idx_next = idx_reg + AW'(1);
                        end
                    end
                end
                // A channel-1 point before the first channel-0 point is skipped so index 0 pairs up.
                if (CHANNELS == 2 && started_reg && d_reg == DW'(CLK_DIV_PDM - 1)) begin
                    wr_ch1 = 1'b1;
                    if (idx_reg == AW'(DEPTH - 1)) begin
                        cap_done = 1'b1;
                    end else begin
                        idx_next = idx_reg + AW'(1);
                    end
                end
                if (cap_done) begin
                    state_next   = DUMP;
                    toggle_next  = ~toggle_reg;
                    idx_next     = '0;
                    chan_next    = 1'b0;
                    phase_next   = 2'd0;
                    bit_next     = 4'd0;
                    baud_next    = '0;
                    started_next = 1'b0;
                end
            end

            DUMP: begin
                if (baud_reg == BW'(BAUD_DIV - 1)) begin
                    baud_next = '0;
                    if (bit_reg == 4'(FRAME_BITS - 1)) begin
                        bit_next = 4'd0;
                        if (phase_reg == 2'd0) begin
                            if (idx_reg == AW'(DEPTH - 1)) begin
                                idx_next = '0;
                                if (CRLF_EN) begin
                                    phase_next = 2'd1;
                                end else begin
                                    blk_end = 1'b1;
                                end
                            end else begin
                                idx_next = idx_reg + AW'(1);
                            end
                        end else if (phase_reg == 2'd1) begin
                            phase_next = 2'd2;
                        end else begin
                            phase_next = 2'd0;
                            blk_end    = 1'b1;
                        end
                        if (blk_end) begin
                            if (chan_reg == 1'(CHANNELS - 1)) begin
                                state_next = IDLE;
                            end else begin
                                chan_next = 1'b1;
                            end
                        end
                    end else begin
                        bit_next = bit_reg + 4'd1;
                    end
                end else begin
                    baud_next = baud_reg + BW'(1);
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // Line level follows the next-cycle bit position so the wire and the state stay aligned.
        // Data bits are needed only after a full start bit, by which time the buffer read has settled.
        if (state_next == DUMP) begin
            if (bit_next == 4'd0) begin
                tx_next = 1'b0;
            end else if (bit_next <= 4'd8) begin
                tx_next = char_code[3'(bit_next - 4'd1)];
            end else begin
                tx_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            chan_reg    <= 1'b0;
            phase_reg   <= 2'd0;
            bit_reg     <= 4'd0;
            baud_reg    <= '0;
            started_reg <= 1'b0;
            toggle_reg  <= 1'b0;
            tx_reg      <= 1'b1;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            chan_reg    <= chan_next;
            phase_reg   <= phase_next;
            bit_reg     <= bit_next;
            baud_reg    <= baud_next;
            started_reg <= started_next;
            toggle_reg  <= toggle_next;
            tx_reg      <= tx_next;
        end
    end

    assign pdm_clk      = pdm_clk_reg;
    assign ftdi_tx      = tx_reg;
    assign busy         = (state_reg != IDLE);
    assign frame_toggle = toggle_reg;

endmodule

// File: tb/tb_pdm_capture_dump.sv
// Randomised bench for pdm_capture_dump: stereo microphone model, UART receiver and character scoreboard.
`timescale 1ns/1ps
module tb_pdm_capture_dump;

    localparam int N  = 8;
    localparam int B  = 16;
    localparam int D  = 8;
    localparam int CH = 2;
    localparam int SB = 2;
    localparam int F  = 9 + SB;
    localparam int FRAME_CYC = F * B;
`ifdef PDM_DUMP_CRLF_EN
    localparam bit CRLF = 1'b1;
`else
    localparam bit CRLF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ftdi_rx = 1'b1;
    logic pdm_dat = 1'b0;
    logic pdm_clk, ftdi_tx, busy, frame_toggle;
    logic rx12 = 1'b1;
    logic dat12 = 1'b0;
    logic pdm_clk12, ftdi_tx12, busy12, toggle12;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    pdm_capture_dump #(
        .CLK_DIV_PDM(N), .BAUD_DIV(B), .DEPTH(D), .CHANNELS(CH), .STOP_BITS(SB)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .ftdi_rx(ftdi_rx), .pdm_dat(pdm_dat),
        .pdm_clk(pdm_clk), .ftdi_tx(ftdi_tx), .busy(busy), .frame_toggle(frame_toggle)
    );

    pdm_capture_dump #(
        .CLK_DIV_PDM(12), .BAUD_DIV(16), .DEPTH(8), .CHANNELS(1), .STOP_BITS(1)
    ) u_dut12 (
        .clk(clk), .rst_n(rst_n), .ftdi_rx(rx12), .pdm_dat(dat12),
        .pdm_clk(pdm_clk12), .ftdi_tx(ftdi_tx12), .busy(busy12), .frame_toggle(toggle12)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Stereo microphone model: ch0 mic drives during pdm_clk high, ch1 mic during pdm_clk low.
    int drv_mode = 0;
    bit rec_arm  = 1'b0;
    bit rec_on   = 1'b0;
    int exp0[$];
    int exp1[$];
    bit drv_p    = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (!drv_p && pdm_clk) begin
                pdm_dat = (drv_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
                if (rec_arm && !rec_on) rec_on = 1'b1;
                if (rec_on && exp0.size() < D) exp0.push_back(int'(pdm_dat));
            end else if (drv_p && !pdm_clk) begin
                pdm_dat = (drv_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
                if (rec_on && exp1.size() < D) exp1.push_back(int'(pdm_dat));
            end
            drv_p = pdm_clk;
        end
    end

    // UART receiver: records byte, start cycle and framing health of every character.
    typedef struct {
        int code;
        int st;
        int ok;
    } rxc_t;
    rxc_t rxq[$];
    initial begin
        bit tp;
        int st, code, ok;
        tp = 1'b1;
        forever begin
            @(negedge clk);
            if (tp && !ftdi_tx) begin
                st = cyc; code = 0; ok = 1;
                repeat (B / 2) @(negedge clk);
                if (ftdi_tx) ok = 0;
                for (int k = 0; k < 8; k++) begin
                    repeat (B) @(negedge clk);
                    code = code | ((ftdi_tx ? 1 : 0) << k);
                end
                for (int s = 0; s < SB; s++) begin
                    repeat (B) @(negedge clk);
                    if (!ftdi_tx) ok = 0;
                end
                repeat (B / 2 - 1) @(negedge clk);
                if (!ftdi_tx) ok = 0;
                rxq.push_back('{code, st, ok});
            end
            tp = ftdi_tx;
        end
    end

    int busy_fall_cyc  = -1;
    int busy_high_cnt  = 0;
    int toggle_cnt     = 0;
    initial begin
        bit bp, tq;
        bp = 1'b0; tq = 1'b0;
        forever begin
            @(negedge clk);
            if (bp && !busy) busy_fall_cyc = cyc;
            if (busy) busy_high_cnt++;
            if (frame_toggle != tq) toggle_cnt++;
            bp = busy;
            tq = frame_toggle;
        end
    end

    function automatic bit pclk(input int sel);
        return (sel != 0) ? pdm_clk12 : pdm_clk;
    endfunction

    task automatic check_pdm_period(input int sel, input int half);
        bit v, p;
        int hi, lo;
        p = pclk(sel);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            v = pclk(sel);
            if (v && !p) break;
            p = v;
        end
        for (int per = 0; per < 10; per++) begin
            hi = 1; lo = 0;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                if (pclk(sel)) hi++; else break;
            end
            lo = 1;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                if (!pclk(sel)) lo++; else break;
            end
            check($sformatf("pdm%0d_high_p%0d", sel, per), hi, half);
            check($sformatf("pdm%0d_low_p%0d", sel, per), lo, half);
        end
        $display("pdm_clk instance %0d: 10 periods measured, half period %0d", sel, half);
    endtask

    task automatic prepare(input int mode);
        drv_mode = mode;
        rec_arm = 1'b0;
        rec_on = 1'b0;
        exp0.delete();
        exp1.delete();
        rxq.delete();
        toggle_cnt = 0;
        busy_fall_cyc = -1;
    endtask

    // Drop rx just after pdm_clk falls so capture is running before the next ch0 sample point.
    task automatic trigger_at_fall();
        bit p;
        @(negedge clk);
        p = pdm_clk;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (p && !pdm_clk) break;
            p = pdm_clk;
        end
        ftdi_rx = 1'b0;
        rec_arm = 1'b1;
        repeat (4) @(negedge clk);
        ftdi_rx = 1'b1;
    endtask

    task automatic run_dump(input int id, input int mode, input bit extra);
        int exp_q[$];
        int n;
        prepare(mode);
        trigger_at_fall();
        if (extra) begin
            repeat (16) @(negedge clk);
            ftdi_rx = 1'b0;
            repeat (4) @(negedge clk);
            ftdi_rx = 1'b1;
        end
        for (int i = 0; i < 4000 && exp1.size() < D; i++) @(negedge clk);
        check($sformatf("d%0d_model_samples", id), exp1.size(), D);
        foreach (exp0[i]) exp_q.push_back(8'h30 + exp0[i]);
        if (CRLF) begin exp_q.push_back(8'h0D); exp_q.push_back(8'h0A); end
        foreach (exp1[i]) exp_q.push_back(8'h30 + exp1[i]);
        if (CRLF) begin exp_q.push_back(8'h0D); exp_q.push_back(8'h0A); end
        n = exp_q.size();
        if (extra) begin
            for (int i = 0; i < 4 * FRAME_CYC && rxq.size() < 3; i++) @(negedge clk);
            ftdi_rx = 1'b0;
            repeat (2 * B) @(negedge clk);
            ftdi_rx = 1'b1;
        end
        for (int i = 0; i < (n + 2) * FRAME_CYC && rxq.size() < n; i++) @(negedge clk);
        repeat (3 * FRAME_CYC) @(negedge clk);
        check($sformatf("d%0d_char_count", id), rxq.size(), n);
        for (int i = 0; i < n && i < rxq.size(); i++) begin
            check($sformatf("d%0d_char%0d", id, i), rxq[i].code, exp_q[i]);
            check($sformatf("d%0d_frame%0d", id, i), rxq[i].ok, 1);
            if (i > 0) check($sformatf("d%0d_spacing%0d", id, i), rxq[i].st - rxq[i-1].st, FRAME_CYC);
        end
        if (rxq.size() > 0)
            check($sformatf("d%0d_busy_fall", id), busy_fall_cyc, rxq[rxq.size()-1].st + FRAME_CYC);
        check($sformatf("d%0d_toggles", id), toggle_cnt, 1);
        check($sformatf("d%0d_busy_idle", id), busy, 0);
        check($sformatf("d%0d_tx_idle", id), ftdi_tx, 1);
        $display("dump %0d: mode %0d extra_edges %0d, %0d chars expected, %0d received, %0d toggles",
                 id, mode, extra, n, rxq.size(), toggle_cnt);
    endtask

    task automatic reset_mid_char();
        int sz;
        prepare(0);
        trigger_at_fall();
        for (int i = 0; i < 4 * FRAME_CYC + 200 && rxq.size() < 2; i++) @(negedge clk);
        check("abort_two_chars_seen", rxq.size(), 2);
        repeat (3 * B) @(negedge clk);
        check("abort_pre_tx_low", ftdi_tx, 0);
        #1 rst_n = 1'b0;
        #1;
        check("abort_tx_high", ftdi_tx, 1);
        check("abort_busy_low", busy, 0);
        check("abort_toggle_low", frame_toggle, 0);
        check("abort_pdm_clk_low", pdm_clk, 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (FRAME_CYC) @(negedge clk);
        busy_high_cnt = 0;
        sz = rxq.size();
        repeat (3 * FRAME_CYC) @(negedge clk);
        check("abort_no_more_chars", rxq.size(), sz);
        check("abort_stays_idle", busy_high_cnt, 0);
        check("abort_tx_idle", ftdi_tx, 1);
        $display("reset abort: tx forced high, %0d chars after release", rxq.size() - sz);
    endtask

    initial begin
        rst_n = 1'b0;
        ftdi_rx = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pdm_clk", pdm_clk, 0);
        check("rst_tx", ftdi_tx, 1);
        check("rst_busy", busy, 0);
        check("rst_toggle", frame_toggle, 0);
        check("rst_pdm_clk12", pdm_clk12, 0);
        rst_n = 1'b1;
        busy_high_cnt = 0;
        repeat (40) @(negedge clk);
        check("low_rx_at_release", busy_high_cnt, 0);
        ftdi_rx = 1'b1;
        repeat (10) @(negedge clk);
        check("rx_rise_no_trigger", busy_high_cnt, 0);
        $display("reset: outputs checked, low rx at release ignored");

        check_pdm_period(0, N / 2);
        check_pdm_period(1, 6);

        run_dump(0, 0, 1'b0);
        run_dump(1, 1, 1'b0);
        run_dump(2, 0, 1'b1);
        reset_mid_char();
        run_dump(3, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
